// File: rtl/bit_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full adder and a carry flop,
// operands consumed LSB first, result, carry and signed overflow held in registers.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   shs_q, shs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic s_bit;
  logic cy_new;
  logic start;

  assign s_bit  = sha_q[0] ^ shb_q[0] ^ cy_q;
  assign cy_new = (sha_q[0] & shb_q[0]) | (sha_q[0] & cy_q) | (shb_q[0] & cy_q);
  // A load is honoured from IDLE and from DONE (back-to-back), never mid-SHIFT.
  assign start  = load && (state_q != SHIFT);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE:  state_d = IDLE;
      SHIFT: begin
        cy_d  = cy_new;
        shs_d = {s_bit, shs_q[WIDTH-1:1]};
        sha_d = {1'b0, sha_q[WIDTH-1:1]};
        shb_d = {1'b0, shb_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {s_bit, shs_q[WIDTH-1:1]};
          carry_d = cy_new;
          ovf_d   = cy_q ^ cy_new;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtraction is A + ~B + 1: invert B on entry and seed the carry with 1.
    if (start) begin
      sha_d   = input_A;
      shb_d   = sub ? ~input_B : input_B;
      cy_d    = sub;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Scoreboard bench for bit_serial_addsub: an 8-bit and a 16-bit instance share
// clock and reset; expected results come from an arithmetic model.
module tb_bit_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        load8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  sum8;
  logic        co8, ov8, busy8, done8;

  logic        load16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] sum16;
  logic        co16, ov16, busy16, done16;

  bit_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .sub(sub8), .input_A(a8), .input_B(b8),
    .sum(sum8), .carry_out(co8), .overflow(ov8), .busy(busy8), .done(done8)
  );

  bit_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .load(load16), .sub(sub16), .input_A(a16), .input_B(b16),
    .sum(sum16), .carry_out(co16), .overflow(ov16), .busy(busy16), .done(done16)
  );

  bit sel16 = 1'b0;
  logic [63:0] obs_sum;
  logic        obs_co, obs_ov, obs_busy, obs_done;
  assign obs_sum  = sel16 ? {48'd0, sum16} : {56'd0, sum8};
  assign obs_co   = sel16 ? co16   : co8;
  assign obs_ov   = sel16 ? ov16   : ov8;
  assign obs_busy = sel16 ? busy16 : busy8;
  assign obs_done = sel16 ? done16 : done8;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input int w);
    exp_t        e;
    logic [64:0] mask;
    logic [64:0] full;
    logic [63:0] aa, bb, res;
    mask = (65'd1 << w) - 65'd1;
    aa   = a & mask[63:0];
    bb   = (s ? ~b : b) & mask[63:0];
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, s};
    res  = full[63:0] & mask[63:0];
    e.sum = res;
    e.co  = full[w];
    e.ov  = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
    return e;
  endfunction

  // Presents a load for one edge; optionally records the expected result.
  task automatic drive_load(input logic [63:0] a, input logic [63:0] b,
                            input logic s, input bit expect_result);
    if (sel16) begin
      a16 = a[15:0]; b16 = b[15:0]; sub16 = s; load16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; load8 = 1'b1;
    end
    if (expect_result) sb.push_back(model(a, b, s, sel16 ? 16 : 8));
    @(negedge clk);
    load8  = 1'b0;
    load16 = 1'b0;
  endtask

  // Counts busy cycles until done, then pops and compares the scoreboard.
  task automatic wait_result(input int busy_init, input bit hold_chk,
                             input logic [63:0] held, input bit chk_pulse);
    int   busy_cnt;
    int   budget;
    bit   hold_bad;
    exp_t e;
    int   w;
    busy_cnt = busy_init;
    budget   = 0;
    hold_bad = 1'b0;
    w        = sel16 ? 16 : 8;
    while (!obs_done && budget < 100) begin
      if (obs_busy) busy_cnt++;
      if (obs_sum !== held) hold_bad = 1'b1;
      @(negedge clk);
      budget++;
    end
    n_tests++;
    if (!obs_done) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      return;
    end
    if (hold_chk) begin
      n_tests++;
      if (hold_bad) begin
        n_fail++;
        $display("FAIL sum_hold: sum changed during operation, required %0h held", held);
      end
    end
    n_tests++;
    if (busy_cnt !== w) begin
      n_fail++;
      $display("FAIL busy_len: got %0d busy cycles, required %0d", busy_cnt, w);
    end
    n_tests++;
    if (obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_done: got %b, required 0", obs_busy);
    end
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: done with no expected result queued");
    end else begin
      e = sb.pop_front();
      n_tests++;
      if (obs_sum !== e.sum) begin
        n_fail++;
        $display("FAIL sum: got %0h, required %0h", obs_sum, e.sum);
      end
      n_tests++;
      if (obs_co !== e.co) begin
        n_fail++;
        $display("FAIL carry_out: got %b, required %b", obs_co, e.co);
      end
      n_tests++;
      if (obs_ov !== e.ov) begin
        n_fail++;
        $display("FAIL overflow: got %b, required %b", obs_ov, e.ov);
      end
    end
    if (chk_pulse) begin
      @(negedge clk);
      n_tests++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse: done=%b busy=%b one cycle later, required 0 0",
                 obs_done, obs_busy);
      end
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] held;
    held = obs_sum;
    drive_load(a, b, s, 1'b1);
    wait_result(0, 1'b1, held, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({sum8, co8, ov8, busy8, done8} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset8: got %h, required 0", {sum8, co8, ov8, busy8, done8});
    end
    n_tests++;
    if ({sum16, co16, ov16, busy16, done16} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset16: got %h, required 0", {sum16, co16, ov16, busy16, done16});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    run_op(64'd3, 64'd2, 1'b0);
    run_op(64'd255, 64'd255, 1'b0);
    run_op(64'd127, 64'd1, 1'b0);
  endtask

  task automatic test_sub;
    run_op(64'd3, 64'd5, 1'b1);
    run_op(64'd128, 64'd1, 1'b1);
    run_op(64'd200, 64'd100, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [63:0] held;
    held = obs_sum;
    drive_load(64'd10, 64'd20, 1'b0, 1'b1);
    @(negedge clk);
    drive_load(64'd99, 64'd99, 1'b0, 1'b0);
    wait_result(2, 1'b1, held, 1'b0);
    held = obs_sum;
    drive_load(64'd5, 64'd6, 1'b1, 1'b1);
    n_tests++;
    if (obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_start: busy=%b after load in DONE, required 1", obs_busy);
    end
    wait_result(0, 1'b1, held, 1'b1);
  endtask

  task automatic test_reset_abort;
    bit saw_done;
    drive_load(64'd200, 64'd100, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({sum8, co8, ov8, busy8} !== 11'd0) begin
      n_fail++;
      $display("FAIL abort_clear: sum=%0h co=%b ov=%b busy=%b, required all 0",
               sum8, co8, ov8, busy8);
    end
    saw_done = 1'b0;
    repeat (12) begin
      if (done8) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_done: done pulsed after reset abort, required none");
    end
    run_op(64'd1, 64'd1, 1'b0);
  endtask

  task automatic test_wide;
    sel16 = 1'b1;
    @(negedge clk);
    run_op(64'h1234, 64'h1111, 1'b0);
    run_op(64'hFFFF, 64'h0001, 1'b0);
    run_op(64'h7FFF, 64'h8000, 1'b1);
    sel16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
